// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the debug unit / pipeline stages and pipeline_ctrl.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             dbg_start;
  logic             dbg_step_mode;
  logic             dbg_step;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_branch_taken;
  logic             id_halt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;

  logic             pipe_en;
  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output dbg_start, dbg_step_mode, dbg_step,
    output id_rs, id_rt, id_uses_rt, id_branch_taken, id_halt,
    output ex_mem_read, ex_rt,
    input  pipe_en, PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
    input  state, cycle_count, stall_count
  );

  modport slave (
    input  dbg_start, dbg_step_mode, dbg_step,
    input  id_rs, id_rt, id_uses_rt, id_branch_taken, id_halt,
    input  ex_mem_read, ex_rt,
    output pipe_en, PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
    output state, cycle_count, stall_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencer for the 5-stage DLX pipeline: load-use stalls, branch flushes,
// HALT drain and run/step/halt debug control, plus cycle and stall counters.
module pipeline_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic            enable,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt, drain_d;
  logic [CNT_W-1:0]   cycle_q, stall_q;

  logic hz_raw;
  logic hz;
  logic halt_go;
  logic pipe_en;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble;

  assign hz_raw = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                  ((bus.ex_rt == bus.id_rs) ||
                   (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    pipe_en      = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_d      = state_q;
    drain_d      = drain_cnt;

    unique case (state_q)
      RUN:     pipe_en = 1'b1;
      STEP:    pipe_en = bus.dbg_step;
      DRAIN:   pipe_en = 1'b1;
      default: pipe_en = 1'b0;
    endcase

    // Hazard check is meaningless while draining: nothing new is issued.
    hz = pipe_en && (state_q != DRAIN) && hz_raw;

    // HALT retires from ID only on a cycle that actually hands over to DRAIN.
    halt_go = pipe_en && bus.id_halt && !hz &&
              (((state_q == RUN)  && !bus.dbg_step_mode) ||
               ((state_q == STEP) &&  bus.dbg_step_mode));

    if (pipe_en) begin
      if (state_q == DRAIN) begin
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (hz) begin
        id_ex_bubble = 1'b1;
      end else if (halt_go) begin
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = bus.id_branch_taken;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.dbg_start) state_d = bus.dbg_step_mode ? STEP : RUN;
      end
      RUN, STEP: begin
        if (bus.dbg_step_mode != (state_q == STEP)) begin
          state_d = bus.dbg_step_mode ? STEP : RUN;
        end else if (halt_go) begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_W'(1)) state_d = HALTED;
        else                          drain_d = drain_cnt - DRAIN_W'(1);
      end
      default: state_d = HALTED;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge enable) begin
    if (!reset) begin
      state_q   <= IDLE;
      drain_cnt <= '0;
      cycle_q   <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      drain_cnt <= drain_d;
      if (pipe_en) cycle_q <= cycle_q + CNT_W'(1);
      if (hz)      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.pipe_en      = pipe_en;
  assign bus.PC_write     = pc_write;
  assign bus.IF_ID_write  = if_id_write;
  assign bus.IF_ID_flush  = if_id_flush;
  assign bus.ID_EX_bubble = id_ex_bubble;
  assign bus.state        = state_q;
  assign bus.cycle_count  = cycle_q;
  assign bus.stall_count  = stall_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencing block for the 5-stage DLX pipeline. It drives the write/flush controls of the IF_ID latch, the PC write enable and the ID_EX bubble insertion. It detects load-use hazards, flushes on taken branches, drains the pipe on a HALT instruction, and provides run, single-step and halt control for the debug unit. It also keeps cycle and stall counters for the debug readout.

Parameters:
CNT_W, 16, width of cycle_count and stall_count
DRAIN_CYCLES, 3, cycles the pipe keeps clocking after HALT leaves ID (EX, MEM, WB)

Ports:
enable  input  1  clock; all state updates on posedge enable
reset  input  1  synchronous, active-low reset
dbg_start  input  1  pulse; leaves IDLE
dbg_step_mode  input  1  1 = single-step, 0 = free run
dbg_step  input  1  pulse; advances one cycle in step mode
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads rt as a source
id_branch_taken  input  1  branch/jump resolved taken in ID
id_halt  input  1  HALT opcode in ID
ex_mem_read  input  1  instruction in EX is a load
ex_rt  input  5  destination rt of the load in EX
pipe_en  output  1  global stage enable for all latches, PC and register file
PC_write  output  1  PC may update
IF_ID_write  output  1  IF_ID latch may load; 0 holds it
IF_ID_flush  output  1  IF_ID loads a NOP
ID_EX_bubble  output  1  ID_EX loads zero control
state  output  3  IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4
cycle_count  output  CNT_W  cycles with pipe_en=1
stall_count  output  CNT_W  load-use stall cycles taken

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, both counters=0.
  - Combinational outputs follow the IDLE decode: pipe_en=0, PC_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=0.
- Hazard decode is combinational and is valid only while pipe_en=1:
  - hz = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).
  - hz=1: PC_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0. id_branch_taken and id_halt are ignored that cycle because the operands are not ready.
  - hz=0 and id_branch_taken=1: PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=0.
  - Otherwise PC_write=1, IF_ID_write=1, flush=0, bubble=0.
- pipe_en by state:
  - IDLE: 0.
  - RUN: 1.
  - STEP: equals dbg_step.
  - DRAIN: 1.
  - HALTED: 0.
  - When pipe_en=0, all four latch controls are 0.
- Transitions (evaluated at posedge enable):
  - IDLE: dbg_start goes to RUN if dbg_step_mode=0, or STEP if dbg_step_mode=1.
  - RUN: dbg_step_mode=1 goes to STEP. Otherwise, id_halt with hz=0 goes to DRAIN and loads the drain counter with DRAIN_CYCLES.
  - STEP: dbg_step_mode=0 goes to RUN. Otherwise, dbg_step with id_halt and hz=0 goes to DRAIN.
  - DRAIN: the counter decrements each cycle and the state moves to HALTED when it reaches 1. dbg_step_mode is ignored in DRAIN.
  - HALTED: stays until reset. dbg_start and dbg_step are ignored.
- DRAIN controls:
  - On the HALT cycle and every DRAIN cycle: PC_write=0, IF_ID_write=1, IF_ID_flush=1, so no new fetch enters.
  - ID_EX_bubble=1 in DRAIN only; the HALT itself advances normally.
  - Hazard decode is suppressed in DRAIN.
- Counters:
  - cycle_count += 1 every edge where pipe_en=1.
  - stall_count += 1 every edge where pipe_en=1 and hz=1.
  - Both wrap modulo 2^CNT_W with no saturation.
- Simultaneous events:
  - dbg_start together with dbg_step in IDLE: only the state change happens; no step is taken.
  - A reset edge overrides everything, including mid-DRAIN and mid-stall; the counters clear.

Test Plan:
- Reset then dbg_start with dbg_step_mode=0 -> state=1 next cycle, pipe_en=1, PC_write=1, IF_ID_write=1, cycle_count counts 1, 2, 3.
- Load-use case, ex_mem_read=1, ex_rt=5, id_rs=5 -> same cycle PC_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_count increments by 1. Repeat with ex_rt=0 -> no stall.
- Load-use with id_rt=5 -> stall when id_uses_rt=1, no stall when id_uses_rt=0.
- id_branch_taken=1 with hz=0 -> IF_ID_flush=1, PC_write=1. With hz=1 in the same cycle -> stall only, flush=0.
- Halt with DRAIN_CYCLES=3: id_halt in RUN -> DRAIN for exactly 3 edges with PC_write=0, then state=4 and pipe_en=0; cycle_count frozen thereafter. Then dbg_start -> no change.
- Step mode: dbg_step_mode=1, two dbg_step pulses 5 cycles apart -> pipe_en high exactly 2 cycles, cycle_count +2. Apply reset mid-DRAIN -> state=0, counters=0 on the next edge.
